// File: rtl/star_bound_mapper_pkg.sv
// Shared sizes, brightness threshold and FSM encoding
// for the star bounding-box mapper.
package star_bound_mapper_pkg;

  localparam int WIDTH     = 6;
  localparam int HEIGHT    = 6;
  localparam int X_SZ      = 3;
  localparam int Y_SZ      = 3;
  localparam int ADDR_SZ   = 6;
  localparam int COL_SZ    = 3;
  localparam int THRESHOLD = 0;
  localparam int CUR_SZ    = (X_SZ > Y_SZ) ? X_SZ : Y_SZ;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    UP_RD   = 4'd1,
    UP_EV   = 4'd2,
    DN_RD   = 4'd3,
    DN_EV   = 4'd4,
    TB_DONE = 4'd5,
    LT_RD   = 4'd6,
    LT_EV   = 4'd7,
    RT_RD   = 4'd8,
    RT_EV   = 4'd9,
    LR_DONE = 4'd10
  } state_t;

  function automatic logic is_bright(
    input logic [COL_SZ-1:0] v
  );
    return v > COL_SZ'(THRESHOLD);
  endfunction

endpackage

// File: rtl/star_bound_mapper_addr.sv
// Row-major pixel address: y*WIDTH + x, zero-extended,
// wrapped to the RAM address width.
module pixel_addr_calc #(
  parameter int WIDTH   = 6,
  parameter int X_SZ    = 3,
  parameter int Y_SZ    = 3,
  parameter int ADDR_SZ = 6
) (
  input  logic [X_SZ-1:0]    i_x,
  input  logic [Y_SZ-1:0]    i_y,
  output logic [ADDR_SZ-1:0] o_addr
);

  localparam logic [ADDR_SZ-1:0] W_L = ADDR_SZ'(WIDTH);

  logic [ADDR_SZ-1:0] w_x;
  logic [ADDR_SZ-1:0] w_y;

  assign w_x    = ADDR_SZ'(i_x);
  assign w_y    = ADDR_SZ'(i_y);
  assign o_addr = w_y * W_L + w_x;

endmodule

// File: rtl/star_bound_mapper.sv
// Walks outward from a bright seed pixel to find the
// star's top/bottom rows and left/right columns.
module star_bound_mapper
  import star_bound_mapper_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               goMapRows,
  input  logic               goMapColumns,
  input  logic [X_SZ-1:0]    seedX,
  input  logic [Y_SZ-1:0]    seedY,
  input  logic [COL_SZ-1:0]  pixVal,
  output logic [ADDR_SZ-1:0] memAddr,
  output logic               topBottomFound,
  output logic               leftFound,
  output logic               rightFound,
  output logic [Y_SZ-1:0]    topY,
  output logic [Y_SZ-1:0]    botY,
  output logic [X_SZ-1:0]    leftX,
  output logic [X_SZ-1:0]    rightX,
  output logic               busy
);

  localparam logic [CUR_SZ-1:0] ONE  = CUR_SZ'(1);
  localparam logic [CUR_SZ-1:0] ZERO = CUR_SZ'(0);
  localparam logic [CUR_SZ-1:0] XMAX = CUR_SZ'(WIDTH - 1);
  localparam logic [CUR_SZ-1:0] YMAX = CUR_SZ'(HEIGHT - 1);

  state_t r_state, w_next;

  logic [CUR_SZ-1:0]  r_cur, w_cur;
  logic [X_SZ-1:0]    r_seedX, w_seedX;
  logic [Y_SZ-1:0]    r_seedY, w_seedY;
  logic [Y_SZ-1:0]    r_topY, w_topY;
  logic [Y_SZ-1:0]    r_botY, w_botY;
  logic [X_SZ-1:0]    r_leftX, w_leftX;
  logic [X_SZ-1:0]    r_rightX, w_rightX;
  logic [Y_SZ-1:0]    r_midY, w_midY;
  logic               r_tb, w_tb;
  logic               r_lf, w_lf;
  logic               r_rf, w_rf;
  logic [ADDR_SZ-1:0] r_addr;

  logic               w_probe;
  logic [X_SZ-1:0]    w_px;
  logic [Y_SZ-1:0]    w_py;
  logic [ADDR_SZ-1:0] w_addr;
  logic [Y_SZ:0]      w_sum;
  logic [Y_SZ-1:0]    w_mid;
  logic               w_row_scan;
  logic               w_col_scan;
  logic               w_abort;
  logic               w_bright;

  pixel_addr_calc #(
    .WIDTH   (WIDTH),
    .X_SZ    (X_SZ),
    .Y_SZ    (Y_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_addr (
    .i_x    (w_px),
    .i_y    (w_py),
    .o_addr (w_addr)
  );

  assign w_sum    = {1'b0, r_topY} + {1'b0, r_botY};
  assign w_mid    = Y_SZ'(w_sum >> 1);
  assign w_bright = is_bright(pixVal);

  assign w_row_scan = (r_state == UP_RD) ||
                      (r_state == UP_EV) ||
                      (r_state == DN_RD) ||
                      (r_state == DN_EV);
  assign w_col_scan = (r_state == LT_RD) ||
                      (r_state == LT_EV) ||
                      (r_state == RT_RD) ||
                      (r_state == RT_EV);

  always_comb begin
    w_abort = 1'b0;
    unique case (1'b1)
      w_row_scan: w_abort = !goMapRows;
      w_col_scan: w_abort = !goMapColumns;
      default:    w_abort = 1'b0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_cur    = r_cur;
    w_seedX  = r_seedX;
    w_seedY  = r_seedY;
    w_topY   = r_topY;
    w_botY   = r_botY;
    w_leftX  = r_leftX;
    w_rightX = r_rightX;
    w_midY   = r_midY;
    w_tb     = r_tb;
    w_lf     = r_lf;
    w_rf     = r_rf;
    w_probe  = 1'b0;
    w_px     = r_seedX;
    w_py     = r_seedY;
    if (w_abort) begin
      w_next = IDLE;
      w_tb   = 1'b0;
      w_lf   = 1'b0;
      w_rf   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_tb = 1'b0;
          w_lf = 1'b0;
          w_rf = 1'b0;
          if (goMapRows) begin
            w_seedX = seedX;
            w_seedY = seedY;
            w_cur   = CUR_SZ'(seedY);
            w_next  = UP_RD;
          end else if (goMapColumns) begin
            w_midY = w_mid;
            w_cur  = CUR_SZ'(r_seedX);
            w_next = LT_RD;
          end
        end
        UP_RD: begin
          if (r_cur == ZERO) begin
            w_topY = '0;
            w_cur  = CUR_SZ'(r_seedY);
            w_next = DN_RD;
          end else begin
            w_probe = 1'b1;
            w_py    = Y_SZ'(r_cur - ONE);
            w_next  = UP_EV;
          end
        end
        UP_EV: begin
          if (w_bright) begin
            w_cur  = r_cur - ONE;
            w_next = UP_RD;
          end else begin
            w_topY = Y_SZ'(r_cur);
            w_cur  = CUR_SZ'(r_seedY);
            w_next = DN_RD;
          end
        end
        DN_RD: begin
          if (r_cur == YMAX) begin
            w_botY = Y_SZ'(r_cur);
            w_next = TB_DONE;
          end else begin
            w_probe = 1'b1;
            w_py    = Y_SZ'(r_cur + ONE);
            w_next  = DN_EV;
          end
        end
        DN_EV: begin
          if (w_bright) begin
            w_cur  = r_cur + ONE;
            w_next = DN_RD;
          end else begin
            w_botY = Y_SZ'(r_cur);
            w_next = TB_DONE;
          end
        end
        TB_DONE: begin
          w_tb = goMapRows;
          if (!goMapRows) w_next = IDLE;
        end
        LT_RD: begin
          if (r_cur == ZERO) begin
            w_leftX = '0;
            w_lf    = 1'b1;
            w_cur   = CUR_SZ'(r_seedX);
            w_next  = RT_RD;
          end else begin
            w_probe = 1'b1;
            w_px    = X_SZ'(r_cur - ONE);
            w_py    = r_midY;
            w_next  = LT_EV;
          end
        end
        LT_EV: begin
          if (w_bright) begin
            w_cur  = r_cur - ONE;
            w_next = LT_RD;
          end else begin
            w_leftX = X_SZ'(r_cur);
            w_lf    = 1'b1;
            w_cur   = CUR_SZ'(r_seedX);
            w_next  = RT_RD;
          end
        end
        RT_RD: begin
          if (r_cur == XMAX) begin
            w_rightX = X_SZ'(r_cur);
            w_next   = LR_DONE;
          end else begin
            w_probe = 1'b1;
            w_px    = X_SZ'(r_cur + ONE);
            w_py    = r_midY;
            w_next  = RT_EV;
          end
        end
        RT_EV: begin
          if (w_bright) begin
            w_cur  = r_cur + ONE;
            w_next = RT_RD;
          end else begin
            w_rightX = X_SZ'(r_cur);
            w_next   = LR_DONE;
          end
        end
        LR_DONE: begin
          w_lf = goMapColumns;
          w_rf = goMapColumns;
          if (!goMapColumns) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Address only moves on a real probe; bound checks hold it.
  assign memAddr = w_probe ? w_addr : r_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cur    <= '0;
      r_seedX  <= '0;
      r_seedY  <= '0;
      r_topY   <= '0;
      r_botY   <= '0;
      r_leftX  <= '0;
      r_rightX <= '0;
      r_midY   <= '0;
      r_tb     <= 1'b0;
      r_lf     <= 1'b0;
      r_rf     <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_next;
      r_cur    <= w_cur;
      r_seedX  <= w_seedX;
      r_seedY  <= w_seedY;
      r_topY   <= w_topY;
      r_botY   <= w_botY;
      r_leftX  <= w_leftX;
      r_rightX <= w_rightX;
      r_midY   <= w_midY;
      r_tb     <= w_tb;
      r_lf     <= w_lf;
      r_rf     <= w_rf;
      r_addr   <= memAddr;
    end
  end

  assign topBottomFound = r_tb;
  assign leftFound      = r_lf;
  assign rightFound     = r_rf;
  assign topY           = r_topY;
  assign botY           = r_botY;
  assign leftX          = r_leftX;
  assign rightX         = r_rightX;
  assign busy           = (r_state != IDLE) &&
                          (r_state != TB_DONE) &&
                          (r_state != LR_DONE);

endmodule

// File: tb/tb_star_bound_mapper.sv
// Directed bench for star_bound_mapper with a
// behavioural box model and a per-cycle compare process.
module tb_star_bound_mapper;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       goMapRows = 1'b0;
  logic       goMapColumns = 1'b0;
  logic [2:0] seedX = '0;
  logic [2:0] seedY = '0;
  logic [2:0] pixVal;
  logic [5:0] memAddr;
  logic       topBottomFound;
  logic       leftFound;
  logic       rightFound;
  logic [2:0] topY;
  logic [2:0] botY;
  logic [2:0] leftX;
  logic [2:0] rightX;
  logic       busy;

  star_bound_mapper dut (
    .clk            (clk),
    .resetn         (resetn),
    .goMapRows      (goMapRows),
    .goMapColumns   (goMapColumns),
    .seedX          (seedX),
    .seedY          (seedY),
    .pixVal         (pixVal),
    .memAddr        (memAddr),
    .topBottomFound (topBottomFound),
    .leftFound      (leftFound),
    .rightFound     (rightFound),
    .topY           (topY),
    .botY           (botY),
    .leftX          (leftX),
    .rightX         (rightX),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [2:0] img [36];
  bit         seen [64];

  always @(posedge clk)
    pixVal <= (memAddr < 6'd36) ? img[memAddr] : 3'd0;

  always @(posedge clk)
    if (busy === 1'b1) seen[memAddr] <= 1'b1;

  int n_pass = 0;
  int n_chk  = 0;
  int exp_top, exp_bot, exp_left, exp_right, exp_lat;

  task automatic chk(input string nm, input int act,
                     input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, want %0d",
                  nm, act, expv);
  endtask

  function automatic bit br(input int x, input int y);
    return img[y * 6 + x] > 3'd0;
  endfunction

  // Expected box and row-scan latency from the image.
  task automatic model(input int sx, input int sy);
    int t, b, m, l, r, up, dn;
    t = sy;
    while (t > 0 && br(sx, t - 1)) t--;
    b = sy;
    while (b < 5 && br(sx, b + 1)) b++;
    m = (t + b) / 2;
    l = sx;
    while (l > 0 && br(l - 1, m)) l--;
    r = sx;
    while (r < 5 && br(r + 1, m)) r++;
    up = (t > 0) ? 2 * (sy - t + 1) : 2 * (sy - t) + 1;
    dn = (b < 5) ? 2 * (b - sy + 1) : 2 * (b - sy) + 1;
    exp_top   = t;
    exp_bot   = b;
    exp_left  = l;
    exp_right = r;
    exp_lat   = up + dn + 1;
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (busy) chk("addr_range", int'(memAddr <= 6'd35), 1);
      if (topBottomFound) begin
        chk("m_top", topY, exp_top);
        chk("m_bot", botY, exp_bot);
      end
      if (leftFound)  chk("m_left", leftX, exp_left);
      if (rightFound) chk("m_right", rightX, exp_right);
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 36; i++) img[i] = 3'd0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    goMapRows = 1'b0;
    goMapColumns = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, memAddr, 0);
    chk({tag, "_tb"}, topBottomFound, 0);
    chk({tag, "_lf"}, leftFound, 0);
    chk({tag, "_rf"}, rightFound, 0);
    chk({tag, "_top"}, topY, 0);
    chk({tag, "_bot"}, botY, 0);
    chk({tag, "_left"}, leftX, 0);
    chk({tag, "_right"}, rightX, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_rows(input int sx, input int sy,
                          output int lat);
    int n;
    seedX = 3'(sx);
    seedY = 3'(sy);
    goMapRows = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (topBottomFound) break;
    end
    chk("rows_done", topBottomFound, 1);
    lat = n - 1;
    chk("rows_lat", lat, exp_lat);
  endtask

  task automatic end_rows();
    goMapRows = 1'b0;
    @(negedge clk);
    chk("tb_clear", topBottomFound, 0);
    chk("tb_idle", busy, 0);
  endtask

  task automatic run_cols();
    int n;
    goMapColumns = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (leftFound && rightFound) break;
    end
    chk("cols_done", int'(leftFound && rightFound), 1);
  endtask

  task automatic end_cols();
    goMapColumns = 1'b0;
    @(negedge clk);
    chk("lr_clear", int'(leftFound || rightFound), 0);
    chk("lr_idle", busy, 0);
  endtask

  task automatic star_img();
    clear_img();
    for (int y = 1; y <= 3; y++)
      for (int x = 2; x <= 4; x++) img[y * 6 + x] = 3'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    bit tb_seen;
    clear_img();
    do_reset();
    check_zero("rst");

    // 3x3 star at rows 1-3, cols 2-4
    star_img();
    model(2, 1);
    run_rows(2, 1, lat);
    chk("star_lat", lat, 9);
    chk("star_top", topY, 1);
    chk("star_bot", botY, 3);
    end_rows();
    run_cols();
    chk("star_left", leftX, 2);
    chk("star_right", rightX, 4);
    chk("star_lf", leftFound, 1);
    chk("star_rf", rightFound, 1);
    end_cols();
    chk("star_keep_top", topY, 1);
    chk("star_keep_right", rightX, 4);

    // single pixel in the corner
    do_reset();
    clear_img();
    img[0] = 3'd7;
    model(0, 0);
    run_rows(0, 0, lat);
    chk("px_lat", lat, 4);
    chk("px_top", topY, 0);
    chk("px_bot", botY, 0);
    end_rows();
    run_cols();
    chk("px_left", leftX, 0);
    chk("px_right", rightX, 0);
    end_cols();
    chk("px_probe_y1", seen[6], 1);
    chk("px_probe_x1", seen[1], 1);
    chk("px_no_y2", seen[12], 0);
    chk("px_no_x2", seen[2], 0);

    // column at the right/bottom edges
    do_reset();
    clear_img();
    img[23] = 3'd3;
    img[29] = 3'd3;
    img[35] = 3'd3;
    model(5, 3);
    run_rows(5, 3, lat);
    chk("col_lat", lat, 8);
    chk("col_top", topY, 3);
    chk("col_bot", botY, 5);
    end_rows();
    run_cols();
    chk("col_left", leftX, 5);
    chk("col_right", rightX, 5);
    end_cols();
    chk("col_no_y6", seen[41], 0);

    // abort after three cycles of a row scan
    do_reset();
    star_img();
    model(2, 1);
    seedX = 3'd2;
    seedY = 3'd1;
    goMapRows = 1'b1;
    tb_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (topBottomFound) tb_seen = 1'b1;
    end
    chk("abort_busy_before", busy, 1);
    goMapRows = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    repeat (4) begin
      if (topBottomFound) tb_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_tb", int'(tb_seen), 0);
    run_rows(2, 1, lat);
    chk("abort_re_lat", lat, 9);
    chk("abort_re_top", topY, 1);
    chk("abort_re_bot", botY, 3);
    end_rows();
    run_cols();
    end_cols();

    // reset while in DN_EV
    goMapRows = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_addr", memAddr, 14);
    resetn = 1'b0;
    goMapRows = 1'b0;
    @(negedge clk);
    check_zero("mid_rst");
    resetn = 1'b1;

    // both requests together: rows first
    star_img();
    model(2, 1);
    goMapColumns = 1'b1;
    run_rows(2, 1, lat);
    chk("both_lat", lat, 9);
    chk("both_no_lf", leftFound, 0);
    chk("both_top", topY, 1);
    chk("both_bot", botY, 3);
    goMapRows = 1'b0;
    @(negedge clk);
    chk("both_idle", busy, 0);
    chk("both_tb_clr", topBottomFound, 0);
    @(negedge clk);
    chk("both_cols_start", busy, 1);
    run_cols();
    chk("both_left", leftX, 2);
    chk("both_right", rightX, 4);
    end_cols();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/star_bound_mapper.md
Name: star_bound_mapper

Overview:
- Measures the bounding box of a star once the scan FSM has found a bright seed pixel.
- Sits directly downstream of the star-search FSM and consumes its goMapRows/goMapColumns requests.
- Returns topBottomFound/leftFound/rightFound and the box coordinates, which the square drawer and star cleaner consume.
- Reads the image through its own synchronous read port on the 36x3 pixel RAM.

Parameters:
- WIDTH, 6, image width in pixels
- HEIGHT, 6, image height in pixels
- X_SZ, 3, x coordinate width
- Y_SZ, 3, y coordinate width
- ADDR_SZ, 6, RAM address width
- COL_SZ, 3, pixel value width
- THRESHOLD, 0, a pixel is bright iff value > THRESHOLD (unsigned)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- goMapRows  in  1  level request: find top/bottom rows
- goMapColumns  in  1  level request: find left/right columns
- seedX  in  X_SZ  x of found bright pixel, sampled when a row scan starts
- seedY  in  Y_SZ  y of found bright pixel, sampled when a row scan starts
- pixVal  in  COL_SZ  RAM q, valid the cycle after memAddr is presented
- memAddr  out  ADDR_SZ  RAM read address = y*WIDTH + x
- topBottomFound  out  1  row scan complete
- leftFound  out  1  left scan complete
- rightFound  out  1  right scan complete
- topY, botY  out  Y_SZ  box rows
- leftX, rightX  out  X_SZ  box columns
- busy  out  1  high in any state other than IDLE, TB_DONE or LR_DONE

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-scan aborts immediately.
- Probe timing: every probe takes 2 cycles. *_RD drives memAddr combinationally; *_EV compares pixVal. memAddr holds its last value outside RD states.
- IDLE:
  - goMapRows=1: latch seedX/seedY, set cur=seedY, go to UP.
  - else goMapColumns=1: go to LT, with row midY=(topY+botY)>>1 and cur=seedX (latched).
  - Both high: rows win.
- UP: if cur==0, topY=0 and go to DN. Else probe (seedX, cur-1). Bright: cur-=1 and repeat. Dark: topY=cur, go to DN.
- DN: restart at cur=seedY. If cur==HEIGHT-1, botY=cur and go to TB_DONE. Else probe cur+1. Bright: continue. Dark: botY=cur.
- TB_DONE: topBottomFound=1 while goMapRows stays high. When goMapRows is low, clear the flag and go to IDLE.
- LT: same as UP, along x on row midY, with bound 0. Result goes to leftX; leftFound is set when LT finishes.
- RT: same as DN, along x with bound WIDTH-1. Result goes to rightX. Then go to LR_DONE.
- LR_DONE: leftFound=rightFound=1 while goMapColumns stays high. When goMapColumns is low, clear both flags and go to IDLE.
- Abort: if the active go signal drops during a scan, go to IDLE next cycle with all flags 0. Coordinate registers keep their partial values.
- Coordinate registers persist until overwritten, so the drawer can read them after the flags drop.
- The seed is not re-probed; it is assumed bright.
- No probe is ever issued outside 0..WIDTH-1 / 0..HEIGHT-1.
- Arithmetic: address computed unsigned with zero-extension; midY truncates.

Decomposition:
- Shared package: WIDTH, HEIGHT, size constants, THRESHOLD, state encoding (4-bit localparams: IDLE, UP_RD, UP_EV, DN_RD, DN_EV, TB_DONE, LT_RD, LT_EV, RT_RD, RT_EV, LR_DONE).
- One sub-module: pixel_addr_calc, parameterised y*WIDTH+x, replacing the fixed 6-wide translator.

Test Plan:
- Star at rows 1-3, cols 2-4, seed (2,1), goMapRows held:
  - Rows: topBottomFound rises 9 cycles after goMapRows is first sampled, with topY=1, botY=3.
  - Columns: then goMapColumns held; expect leftX=2, rightX=4, and leftFound=rightFound=1.
- Single pixel at (0,0): rows probe only y=1 and columns only x=1, giving box (0,0,0,0). Assert memAddr never exceeds 35.
- Column of pixels at x=5, y=3..5, seed (5,3): botY=5 with no probe at y=6. leftX=rightX=5 with no probe at x=6.
- Drop goMapRows after 3 cycles of a scan: IDLE on the next cycle, topBottomFound never pulses. A new request then completes correctly.
- Assert resetn=0 during DN_EV: next cycle all outputs are 0, state is IDLE, memAddr is 0.
- Raise goMapRows and goMapColumns together in IDLE: the row scan runs first; columns start only after goMapRows falls and the block returns to IDLE.
